os_skew_feeder: RTL
===================

OS_SKEW_FEEDER -- requirements
Module: os_skew_feeder

Interface
- REQ-001 Parameter N, default 4: number of array rows (lanes).
- REQ-002 Parameter WIDTH, default 8: bits per lane element.
- REQ-003 Parameter K_LEN, default 16: vectors per tile, minimum 1.
- REQ-004 Parameter FIFO_DEPTH, default 4: input FIFO entries, power of two, minimum 2.
- REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
- REQ-006 rst  input  1  synchronous, active-high reset.
- REQ-007 start  input  1  single-cycle pulse that begins a tile.
- REQ-008 in_valid  input  1  upstream vector valid.
- REQ-009 in_ready  output  1  feeder can accept a vector.
- REQ-010 in_data  input  N*WIDTH  input vector; lane i occupies bits [i*WIDTH +: WIDTH].
- REQ-011 out_data  output  N*WIDTH  skewed vector to array rows, with the same lane packing as in_data.
- REQ-012 out_valid  output  N  per-lane valid; bit i qualifies lane i of out_data.
- REQ-013 busy  output  1  high in FEED or FLUSH.
- REQ-014 tile_done  output  1  single-cycle pulse at tile completion.

Function
- REQ-015 Push: the FIFO SHALL store in_data when in_valid && in_ready.
- REQ-016 in_ready SHALL equal !full; there is no bypass, so in_ready stays 0 when full even if a pop occurs in the same cycle.
- REQ-017 Push and pop in one cycle on a non-full, non-empty FIFO SHALL both occur, leaving occupancy unchanged.
- REQ-018 The FIFO SHALL accept pushes in every state.
- REQ-019 FSM states SHALL be IDLE, FEED and FLUSH.
- REQ-020 IDLE -> FEED on start; the pop counter clears to 0.
- REQ-021 start SHALL be ignored in FEED and FLUSH.
- REQ-022 In FEED, a pop SHALL occur in every cycle in which the FIFO is non-empty.
- REQ-023 A FEED cycle with an empty FIFO SHALL be a bubble: no pop, and the counter holds.
- REQ-024 A pop in cycle t SHALL drive lane i of that vector onto out_data lane i with out_valid[i]=1 in cycle t+1+i.
- REQ-025 A bubble in cycle t SHALL drive out_valid[i]=0 and lane i data 0 in cycle t+1+i, preserving diagonal alignment.
- REQ-026 Outside FEED, the skew input SHALL be a bubble.
- REQ-027 FEED -> FLUSH after the K_LEN-th pop (pop counter reaches K_LEN-1 while popping).
- REQ-028 FLUSH SHALL last exactly N cycles, counted 0..N-1.
- REQ-029 tile_done SHALL be 1 in the FLUSH cycle whose count is N-1, which coincides with the last out_valid[N-1].
- REQ-030 FLUSH -> IDLE after that cycle.
- REQ-031 busy SHALL be 1 exactly in FEED and FLUSH.
- REQ-032 Pop counter width SHALL be clog2(K_LEN+1); flush counter width SHALL be clog2(N+1).
- REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy width SHALL be clog2(FIFO_DEPTH)+1.

Reset
- REQ-034 When rst=1 at a clock edge: state=IDLE, FIFO empty, both counters 0, all skew registers 0.
- REQ-035 Reset SHALL take priority over every other input, including mid-tile: in-flight data is discarded with no tile_done.
- REQ-036 Output values in the cycle after reset: in_ready=1, out_valid=0, out_data=0, busy=0, tile_done=0.

Verification (N=4, WIDTH=8, K_LEN=16, FIFO_DEPTH=4)
- REQ-037 Streaming: push 16 vectors, lanes={v,v+1,v+2,v+3} for v=0,4,...; start; FIFO never empty -> lane i shows the element of pop k at pop cycle+1+i; tile_done exactly 4 cycles after the 16th pop; busy=0 in the next cycle.
- REQ-038 Bubbles: starve the FIFO for 3 cycles after pop 5 -> out_valid[i] is 0 for 3 consecutive cycles beginning pop5_cycle+2+i; alignment of all 16 vectors is intact; tile_done is delayed 3 cycles.
- REQ-039 Backpressure: push 4 vectors while IDLE -> in_ready=0; in_valid held high with a 5th vector is not accepted; after start, the first pop raises in_ready the next cycle and the 5th vector is then accepted.
- REQ-040 Ignored start: pulse start during FEED at pop 8 -> still exactly 16 pops and one tile_done.
- REQ-041 Reset mid-tile: assert rst for 1 cycle after pop 10 -> next cycle all outputs take REQ-036 values, FIFO empty, no tile_done; a new start with 16 fresh vectors completes normally.
- REQ-042 K_LEN=1, N=1 build: 1 push + start -> out_valid[0] in the cycle after the pop; tile_done in that same cycle; then IDLE.

Source files
------------

// File: rtl/os_skew_feeder.sv
// rtl/os_skew_feeder.sv - Tile feeder: input FIFO, IDLE/FEED/FLUSH control and per-lane diagonal skew
// Lane i of each popped vector reaches the array i+1 cycles after its pop.

module os_skew_feeder_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module os_skew_feeder #(
  parameter int N          = 4,
  parameter int WIDTH      = 8,
  parameter int K_LEN      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  output logic               busy,
  output logic               tile_done
);
  localparam int PW = $clog2(K_LEN + 1);
  localparam int FW = $clog2(N + 1);
  localparam logic [PW-1:0] POP_LAST   = PW'(K_LEN - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(N - 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_t;

  state_t             state;
  state_t             state_nx;
  logic [PW-1:0]      pop_cnt;
  logic [PW-1:0]      pop_cnt_nx;
  logic [FW-1:0]      flush_cnt;
  logic [FW-1:0]      flush_cnt_nx;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [N*WIDTH-1:0] fifo_rdata;

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE);

  os_skew_feeder_fifo #(
    .DATA_W (N*WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pop_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      pop_cnt   <= pop_cnt_nx;
      flush_cnt <= flush_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pop_cnt_nx   = pop_cnt;
    flush_cnt_nx = flush_cnt;
    fifo_pop     = 1'b0;
    tile_done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = FEED;
          pop_cnt_nx = '0;
        end
      end
      FEED: begin
        // An empty FIFO is a bubble: nothing popped, count holds.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (pop_cnt == POP_LAST) begin
            state_nx     = FLUSH;
            flush_cnt_nx = '0;
          end else begin
            pop_cnt_nx = pop_cnt + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          tile_done = 1'b1;
          state_nx  = IDLE;
        end else begin
          flush_cnt_nx = flush_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lane i gets an (i+1)-deep delay line; bubbles travel as zero data, valid low.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WIDTH-1:0] d_pipe [i+1];
    logic             v_pipe [i+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          d_pipe[j] <= '0;
          v_pipe[j] <= 1'b0;
        end
      end else begin
        d_pipe[0] <= fifo_pop ? fifo_rdata[i*WIDTH +: WIDTH] : '0;
        v_pipe[0] <= fifo_pop;
        for (int j = 1; j <= i; j++) begin
          d_pipe[j] <= d_pipe[j-1];
          v_pipe[j] <= v_pipe[j-1];
        end
      end
    end

    assign out_data[i*WIDTH +: WIDTH] = d_pipe[i];
    assign out_valid[i]               = v_pipe[i];
  end
endmodule
